clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run-time controller for the programmable clock divider.
- Generates a divided clock clk_out from clk_in with a half-period programmed through a valid/ready config port.
- Ratio changes and start/stop requests apply only at clk_out period boundaries (falling edge), so no output runt pulse is ever produced.
- Also issues single-cycle rise/fall tick strobes so downstream logic can stay on clk_in and use clock enables.

Parameters:
- CW, 8: width of half-period value and internal counter.
- DEF_HALF, 4: half-period, in clk_in cycles, loaded at reset. Must be 1..2^CW-1.
- AUTO_START, 1: 1 = enter RUN after reset; 0 = enter STOP after reset.

Ports:
- clk_in, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- cfg_valid, input, 1: config request valid.
- cfg_ready, output, 1: controller can accept a config.
- cfg_en, input, 1: 1 = run with cfg_half; 0 = stop.
- cfg_half, input, CW: requested half-period in clk_in cycles.
- clk_out, output, 1: divided clock, registered.
- tick_rise, output, 1: high for the single clk_in cycle in which clk_out has just become 1.
- tick_fall, output, 1: high for the single clk_in cycle in which clk_out has just become 0.
- running, output, 1: state != STOP.
- cur_half, output, CW: half-period currently in effect.
- cfg_err, output, 1: one-cycle pulse when an accepted config has cfg_en=1 and cfg_half=0.

Behaviour:
- Reset (rst_n=0 at an edge) sets:
  - clk_out=0, cnt=0, cur_half=DEF_HALF
  - tick_rise=0, tick_fall=0, cfg_err=0
  - pending config discarded
  - state = RUN if AUTO_START=1, else STOP
- Reset mid-operation takes effect at that same edge, regardless of state.
- States: STOP, RUN, PEND.
- cfg_ready = 1 in STOP and RUN, 0 in PEND. A transfer occurs on an edge with cfg_valid & cfg_ready.
- Counting (RUN and PEND):
  - If cnt == cur_half-1: cnt<=0 and clk_out<=~clk_out.
  - Otherwise cnt<=cnt+1.
  - clk_out period is 2*cur_half, 50% duty. cur_half=1 gives clk_in/2.
- Ticks:
  - tick_rise <= 1 at the edge where clk_out goes 0->1; tick_fall <= 1 at the edge where it goes 1->0.
  - Both are 0 otherwise.
- STOP:
  - clk_out held 0, cnt held 0.
  - Transfer with cfg_en=1, cfg_half!=0: at that edge cur_half<=cfg_half, cnt<=0, state<=RUN. clk_out rises at transfer edge + cfg_half.
  - Transfer with cfg_en=0: accepted, no-op.
- RUN:
  - Transfer with cfg_en=0, or with cfg_half!=0: latch (cfg_en, cfg_half) into the pending register, state<=PEND. Counting continues unchanged.
- PEND:
  - Counting continues with the old cur_half.
  - At the edge where clk_out toggles 1->0:
    - If pend_en=0: state<=STOP; clk_out<=0, cnt<=0.
    - If pend_en=1: cur_half<=pend_half, cnt<=0, state<=RUN. The new ratio governs the next low phase.
  - That edge still produces tick_fall=1.
- Invalid config (cfg_en=1 & cfg_half=0):
  - Accepted: handshake completes.
  - cfg_err=1 for exactly one cycle after the transfer edge.
  - No change to state, cur_half or the pending register. Applies in STOP and RUN.
- Pending register holds at most one request; further requests are back-pressured by cfg_ready=0 until the boundary.
- A transfer and the apply boundary can never coincide, since cfg_ready=0 in PEND. On the boundary edge cfg_ready returns to 1 for the next cycle.
- running = 1 in RUN and PEND.
- Arithmetic: cnt is CW bits. Compare against cur_half-1 computed in CW bits. cur_half=2^CW-1 is legal (max period 2*(2^CW-1)).

Test Plan:
- Reset release, AUTO_START=1, DEF_HALF=4: clk_out low cycles 0-3, high 4-7, period 8. tick_rise on cycles 4, 12, ...; tick_fall on 8, 16, ...; cfg_ready=1, running=1.
- Mid-high-phase, send cfg_en=1, cfg_half=2 from RUN (half=4): cfg_ready drops. Old ratio finishes the current high phase; at the falling edge cur_half=2. Next phases are 2 low, 2 high. No phase shorter than 2 or longer than 4.
- Send cfg_en=0 while in RUN (half=3): clk_out completes the high phase, then stays 0. running=0 from the following cycle; ticks stop.
- From STOP, send cfg_en=1, cfg_half=1: clk_out = clk_in/2 starting 1 cycle after transfer. tick_rise alternates with tick_fall every cycle.
- Send cfg_en=1, cfg_half=0 in RUN: cfg_err pulses once. cur_half, state and clk_out waveform unchanged.
- Assert rst_n=0 for one cycle while in PEND: next cycle clk_out=0, cur_half=DEF_HALF, cfg_ready=1, pending request lost. Counting restarts from cnt=0.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for the clock divider controller.
// The master issues (cfg_en, cfg_half) requests; the slave accepts them on cfg_valid & cfg_ready.
interface clk_div_ctrl_if #(
   parameter int CW = 8
);
   logic          cfg_valid;
   logic          cfg_ready;
   logic          cfg_en;
   logic [CW-1:0] cfg_half;

   modport master (
      output cfg_valid,
      output cfg_en,
      output cfg_half,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_en,
      input  cfg_half,
      output cfg_ready
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time controller for a programmable 50%-duty clock divider.
// Ratio and start/stop changes are applied only on clk_out falling edges, so no runt pulses appear.
module clk_div_ctrl #(
   parameter int CW         = 8,
   parameter int DEF_HALF   = 4,
   parameter bit AUTO_START = 1'b1
) (
   input  logic          clk_in,
   input  logic          rst_n,
   clk_div_ctrl_if.slave cfg,
   output logic          clk_out,
   output logic          tick_rise,
   output logic          tick_fall,
   output logic          running,
   output logic [CW-1:0] cur_half,
   output logic          cfg_err
);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [CW-1:0] DEF_HALF_W = CW'(DEF_HALF);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] pend_half;
   logic          pend_en;

   logic          xfer;
   logic          cfg_bad;
   logic          cfg_start;
   logic          wrap;
   logic          boundary;

   assign xfer      = cfg.cfg_valid && (state != ST_PEND);
   assign cfg_bad   = xfer && cfg.cfg_en && (cfg.cfg_half == '0);
   assign cfg_start = xfer && cfg.cfg_en && (cfg.cfg_half != '0);
   assign wrap      = (cnt == (cur_half - CW'(1)));
   // The only point where a pending request may take effect: end of a high phase.
   assign boundary  = (state == ST_PEND) && wrap && clk_out;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state <= AUTO_START ? ST_RUN : ST_STOP;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: default first in every always_comb, otherwise an unassigned path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_STOP: if (cfg_start)          state_nxt = ST_RUN;
         ST_RUN:  if (xfer && !cfg_bad)   state_nxt = ST_PEND;
         ST_PEND: if (boundary)           state_nxt = pend_en ? ST_RUN : ST_STOP;
         default:                         state_nxt = ST_STOP;
      endcase
   end

   always_comb begin
      cfg.cfg_ready = (state != ST_PEND);
      running       = (state != ST_STOP);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         clk_out   <= 1'b0;
         cnt       <= '0;
         cur_half  <= DEF_HALF_W;
         tick_rise <= 1'b0;
         tick_fall <= 1'b0;
         cfg_err   <= 1'b0;
         pend_en   <= 1'b0;
         pend_half <= '0;
      end else begin
         tick_rise <= 1'b0;
         tick_fall <= 1'b0;
         cfg_err   <= cfg_bad;
         if (state == ST_STOP) begin
            clk_out <= 1'b0;
            cnt     <= '0;
            if (cfg_start) cur_half <= cfg.cfg_half;
         end else begin
            if (wrap) begin
               cnt       <= '0;
               clk_out   <= ~clk_out;
               tick_rise <= ~clk_out;
               tick_fall <= clk_out;
            end else begin
               cnt <= cnt + CW'(1);
            end
            // A stop request needs nothing extra here: the falling toggle already leaves clk_out low.
            if (boundary && pend_en) cur_half <= pend_half;
            if ((state == ST_RUN) && xfer && !cfg_bad) begin
               pend_en   <= cfg.cfg_en;
               pend_half <= cfg.cfg_half;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a phase-position model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_clk_div_ctrl;
   localparam int CW         = 8;
   localparam int DEF_HALF   = 4;
   localparam bit AUTO_START = 1'b1;

   logic          clk_in = 1'b0;
   logic          rst_n;
   logic          clk_out;
   logic          tick_rise;
   logic          tick_fall;
   logic          running;
   logic [CW-1:0] cur_half;
   logic          cfg_err;

   clk_div_ctrl_if #(.CW(CW)) cfg_if ();

   clk_div_ctrl #(
      .CW        (CW),
      .DEF_HALF  (DEF_HALF),
      .AUTO_START(AUTO_START)
   ) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .cfg      (cfg_if.slave),
      .clk_out  (clk_out),
      .tick_rise(tick_rise),
      .tick_fall(tick_fall),
      .running  (running),
      .cur_half (cur_half),
      .cfg_err  (cfg_err)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic          clk_out;
      logic          tick_rise;
      logic          tick_fall;
      logic          running;
      logic          cfg_err;
      logic          cfg_ready;
      logic [CW-1:0] cur_half;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Model: position inside the current 2*half period; high while pos >= half.
   bit m_active;
   bit m_pend;
   bit m_pend_en;
   int m_pend_half;
   int m_cur;
   int m_pos;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic exp_t model_step(input bit rstn, input bit valid, input bit en, input int half);
      exp_t e;
      bit   acc;
      bit   bad;
      bit   old_hi;
      bit   new_hi;
      e.tick_rise = 1'b0;
      e.tick_fall = 1'b0;
      e.cfg_err   = 1'b0;
      if (!rstn) begin
         m_active    = AUTO_START;
         m_pend      = 1'b0;
         m_pend_en   = 1'b0;
         m_pend_half = 0;
         m_cur       = DEF_HALF;
         m_pos       = 0;
      end else begin
         acc       = valid && !m_pend;
         bad       = acc && en && (half == 0);
         e.cfg_err = bad;
         if (m_active) begin
            old_hi      = (m_pos >= m_cur);
            m_pos       = (m_pos + 1) % (2 * m_cur);
            new_hi      = (m_pos >= m_cur);
            e.tick_rise = !old_hi && new_hi;
            e.tick_fall = old_hi && !new_hi;
            if (m_pend && e.tick_fall) begin
               m_pend = 1'b0;
               if (m_pend_en) m_cur = m_pend_half;
               else           m_active = 1'b0;
            end else if (!m_pend && acc && !bad) begin
               m_pend      = 1'b1;
               m_pend_en   = en;
               m_pend_half = half;
            end
         end else if (acc && en && (half != 0)) begin
            m_active = 1'b1;
            m_cur    = half;
            m_pos    = 0;
         end
      end
      e.clk_out   = m_active && (m_pos >= m_cur);
      e.running   = m_active;
      e.cur_half  = CW'(m_cur);
      e.cfg_ready = !m_pend;
      return e;
   endfunction

   task automatic cycle(input bit rstn, input bit valid, input bit en, input int half, output bit accepted);
      accepted         = rstn && valid && !m_pend;
      rst_n            = rstn;
      cfg_if.cfg_valid = valid;
      cfg_if.cfg_en    = en;
      cfg_if.cfg_half  = CW'(half);
      exp_q.push_back(model_step(rstn, valid, en, half));
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, acc);
   endtask

   task automatic send(input bit en, input int half);
      bit acc = 1'b0;
      int guard = 0;
      while (!acc && guard < 1200) begin
         cycle(1'b1, 1'b1, en, half, acc);
         guard++;
      end
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout at %0t: got not accepted expected accepted", $time);
      end
   endtask

   task automatic wait_high_phase();
      int guard = 0;
      while (!(m_active && m_pos == m_cur + 1) && guard < 1200) begin
         idle(1);
         guard++;
      end
      if (guard >= 1200) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_high_timeout at %0t: got no high phase expected high phase", $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("clk_out",   32'(clk_out),          32'(e.clk_out));
            check("tick_rise", 32'(tick_rise),        32'(e.tick_rise));
            check("tick_fall", 32'(tick_fall),        32'(e.tick_fall));
            check("running",   32'(running),          32'(e.running));
            check("cfg_err",   32'(cfg_err),          32'(e.cfg_err));
            check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(e.cfg_ready));
            check("cur_half",  32'(cur_half),         32'(e.cur_half));
         end
      end
   end

   initial begin : stimulus
      bit acc;
      bit req;
      bit r_en;
      int r_half;
      int k;

      cycle(1'b0, 1'b0, 1'b0, 0, acc);
      cycle(1'b0, 1'b0, 1'b0, 0, acc);
      idle(20);

      wait_high_phase();
      send(1'b1, 2);
      idle(20);

      send(1'b1, 3);
      idle(12);
      wait_high_phase();
      send(1'b0, 0);
      idle(16);

      send(1'b1, 1);
      idle(10);

      send(1'b1, 0);
      idle(10);
      send(1'b0, 0);
      idle(6);
      send(1'b1, 0);
      idle(4);

      send(1'b1, 5);
      send(1'b1, 6);
      idle(2);
      cycle(1'b0, 1'b0, 1'b0, 0, acc);
      idle(20);

      send(1'b1, 255);
      idle(600);
      send(1'b1, 3);
      idle(530);

      req    = 1'b0;
      r_en   = 1'b0;
      r_half = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!req && $urandom_range(0, 5) == 0) begin
            req = 1'b1;
            r_en = ($urandom_range(0, 5) != 0);
            k = $urandom_range(0, 9);
            if (k == 0)      r_half = 0;
            else if (k == 1) r_half = $urandom_range(7, 20);
            else             r_half = $urandom_range(1, 4);
         end
         cycle(($urandom_range(0, 499) != 0), req, r_en, r_half, acc);
         if (acc) req = 1'b0;
      end

      @(negedge clk_in);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
